axi4_wr_arbiter: RTL and testbench
==================================

Name: axi4_wr_arbiter

Overview:
- Round-robin arbiter that shares one AXI4 write port (AW/W/B channels) between NUM_PORTS simple burst requesters.
- Sits between DMA/packet engines and the memory-side AXI4 write interface (DRAM/interconnect).
- Each requester presents address, length and a write-data stream. The arbiter issues AW, forwards W beats from the granted requester, collects B, and returns the response to that requester.
- One transaction outstanding at a time.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8)
- DWIDTH, 64, data width in bits (power of two, >=8)
- AWIDTH, 32, address width
- IDWIDTH, 4, AXI ID width (must satisfy 2**IDWIDTH >= NUM_PORTS)

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_PORTS  per-port burst request
- req_ready  out  NUM_PORTS  per-port request accept
- req_addr  in  NUM_PORTS*AWIDTH  per-port start address, port i at slice i
- req_len  in  NUM_PORTS*8  per-port AXI len (beats-1)
- s_w_data  in  NUM_PORTS*DWIDTH  per-port write data
- s_w_strb  in  NUM_PORTS*DWIDTH/8  per-port byte strobes
- s_w_last  in  NUM_PORTS  per-port last flag (checked only)
- s_w_valid  in  NUM_PORTS
- s_w_ready  out  NUM_PORTS
- done_valid  out  NUM_PORTS  one-cycle completion pulse to the granted port
- done_resp  out  2  BRESP of the completed burst, valid with done_valid
- err_len  out  1  sticky: s_w_last mismatched beat count
- err_id  out  1  sticky: m_b_id != granted port index
- m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_lock, m_aw_cache, m_aw_prot, m_aw_qos  out  IDWIDTH/AWIDTH/8/3/2/1/4/3/4  AXI4 AW
- m_aw_valid  out 1; m_aw_ready  in 1
- m_w_data  out DWIDTH; m_w_strb  out DWIDTH/8; m_w_last  out 1; m_w_valid  out 1; m_w_ready  in 1
- m_b_id  in IDWIDTH; m_b_resp  in 2; m_b_valid  in 1; m_b_ready  out 1

Behaviour:
- FSM states: IDLE, ADDR, DATA, RESP. Reset state is IDLE.
- Reset values: all outputs 0; grant 0; beat counter 0; err flags 0; last_grant = NUM_PORTS-1, so port 0 wins first.
- Reset is asynchronous and takes effect mid-transaction: no completion pulse is produced and the counter is cleared.
- IDLE, any req_valid set:
  - Grant the first set bit searching from last_grant+1 upward, wrapping modulo NUM_PORTS.
  - Register grant, addr and len; go to ADDR on the next cycle. Request-to-m_aw_valid latency is 1 cycle.
  - A requester that deasserts req_valid before its grant is ignored.
- ADDR:
  - m_aw_valid=1; m_aw_addr and m_aw_len come from the registered values.
  - m_aw_id = grant index, zero-extended.
  - m_aw_size = log2(DWIDTH/8); m_aw_burst = 2'b01 (INCR); lock, cache, prot and qos are 0.
  - req_ready[grant] = m_aw_ready, combinational, so it is high only in the AW handshake cycle.
  - On handshake: go to DATA and clear the beat counter.
- DATA:
  - m_w_data, m_w_strb and m_w_valid are muxed combinationally from the granted port.
  - s_w_ready[grant] = m_w_ready; all other s_w_ready are 0.
  - m_w_last = (counter == len), generated by the arbiter; s_w_last is ignored for framing.
  - Each handshake increments the counter.
  - On a handshake with mismatch (s_w_last != m_w_last): set err_len. Data still flows.
  - Handshake on the last beat: go to RESP.
  - len=0 is a single beat with last asserted.
  - W never starts before the AW handshake.
- RESP:
  - m_b_ready=1.
  - On m_b_valid:
    - done_valid[grant] pulses for 1 cycle in the following cycle, with done_resp = m_b_resp.
    - Set err_id if the ID mismatches.
    - last_grant <= grant; go to IDLE.
- Minimum turnaround: a new grant can be made in the IDLE cycle after RESP, i.e. the cycle in which done_valid pulses.
- Fairness: with all ports requesting continuously, grants rotate 0,1,...,N-1,0.
- Backpressure: any number of stall cycles on m_aw_ready, m_w_ready, s_w_valid or m_b_valid is tolerated. Registered state holds unchanged while stalled.

Test Plan:
- Port 2 alone, addr 0x1000, len 3, full throughput → AW with id=2, len=3, size=3, burst=1 one cycle after req_valid; 4 W beats with last on beat 4. After B OKAY, done_valid[2] pulses with done_resp=0.
- Ports 0, 1 and 3 request simultaneously and hold; each len 0 → grant order 0,1,3,0. Only the granted port ever sees req_ready or s_w_ready.
- Port 1, len 7, with m_w_ready toggling every other cycle and s_w_valid dropped for 3 cycles mid-burst → exactly 8 beats forwarded in order with no duplicate or lost data; m_w_last only on beat 8.
- B returns resp=2'b10 with m_b_id=0 while port 1 is granted → done_resp=2 on done_valid[1]; err_id sets and stays high until reset.
- Port 0, len 3, with s_w_last asserted on beat 2 → err_len sets; 4 beats are still sent; m_w_last on beat 4 only.
- reset_n asserted low during beat 3 of a len-7 burst → all outputs 0 asynchronously. After release, a new port-0 request proceeds from IDLE with a fresh count and no stray done_valid.

Source files
------------

// File: rtl/axi4_wr_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi4_wr_arbiter_if : requester-side bursts plus the shared AXI4 write port
// Rev 1.0
// ---------------------------------------------------------------------------
interface axi4_wr_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int DWIDTH    = 64,
  parameter int AWIDTH    = 32,
  parameter int IDWIDTH   = 4
);
  logic [NUM_PORTS-1:0]          req_valid;
  logic [NUM_PORTS-1:0]          req_ready;
  logic [NUM_PORTS*AWIDTH-1:0]   req_addr;
  logic [NUM_PORTS*8-1:0]        req_len;
  logic [NUM_PORTS*DWIDTH-1:0]   s_w_data;
  logic [NUM_PORTS*DWIDTH/8-1:0] s_w_strb;
  logic [NUM_PORTS-1:0]          s_w_last;
  logic [NUM_PORTS-1:0]          s_w_valid;
  logic [NUM_PORTS-1:0]          s_w_ready;
  logic [NUM_PORTS-1:0]          done_valid;
  logic [1:0]                    done_resp;
  logic                          err_len;
  logic                          err_id;

  logic [IDWIDTH-1:0]  m_aw_id;
  logic [AWIDTH-1:0]   m_aw_addr;
  logic [7:0]          m_aw_len;
  logic [2:0]          m_aw_size;
  logic [1:0]          m_aw_burst;
  logic                m_aw_lock;
  logic [3:0]          m_aw_cache;
  logic [2:0]          m_aw_prot;
  logic [3:0]          m_aw_qos;
  logic                m_aw_valid;
  logic                m_aw_ready;
  logic [DWIDTH-1:0]   m_w_data;
  logic [DWIDTH/8-1:0] m_w_strb;
  logic                m_w_last;
  logic                m_w_valid;
  logic                m_w_ready;
  logic [IDWIDTH-1:0]  m_b_id;
  logic [1:0]          m_b_resp;
  logic                m_b_valid;
  logic                m_b_ready;

  // master: the arbiter itself, driving the AXI4 write port
  modport master (
    input  req_valid, req_addr, req_len, s_w_data, s_w_strb, s_w_last, s_w_valid,
    output req_ready, s_w_ready, done_valid, done_resp, err_len, err_id,
    output m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_lock,
           m_aw_cache, m_aw_prot, m_aw_qos, m_aw_valid,
    input  m_aw_ready,
    output m_w_data, m_w_strb, m_w_last, m_w_valid,
    input  m_w_ready, m_b_id, m_b_resp, m_b_valid,
    output m_b_ready
  );

  modport slave (
    output req_valid, req_addr, req_len, s_w_data, s_w_strb, s_w_last, s_w_valid,
    input  req_ready, s_w_ready, done_valid, done_resp, err_len, err_id,
    input  m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_lock,
           m_aw_cache, m_aw_prot, m_aw_qos, m_aw_valid,
    output m_aw_ready,
    input  m_w_data, m_w_strb, m_w_last, m_w_valid,
    output m_w_ready, m_b_id, m_b_resp, m_b_valid,
    input  m_b_ready
  );
endinterface
`default_nettype wire

// File: rtl/axi4_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi4_wr_arbiter : round-robin sharing of one AXI4 write port, one burst at a time
// Rev 1.0
// ---------------------------------------------------------------------------
module axi4_wr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DWIDTH    = 64,
  parameter int AWIDTH    = 32,
  parameter int IDWIDTH   = 4
) (
  input logic               clk,
  input logic               reset_n,
  axi4_wr_arbiter_if.master bus
);
  localparam int         GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int         SW        = DWIDTH / 8;
  localparam logic [2:0] C_AW_SIZE = 3'($clog2(SW));

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [AWIDTH-1:0]    addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 err_len_q, err_len_d;
  logic                 err_id_q, err_id_d;
  logic [NUM_PORTS-1:0] done_valid_q, done_valid_d;
  logic [1:0]           done_resp_q, done_resp_d;

  logic                 found;
  logic [GW-1:0]        pick;
  logic                 beat_last;

  // Search starts just past the previous winner so every port gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!found && bus.req_valid[(int'(last_grant_q) + k) % NUM_PORTS]) begin
        found = 1'b1;
        pick  = GW'((int'(last_grant_q) + k) % NUM_PORTS);
      end
    end
  end

  assign beat_last = (cnt_q == len_q);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    err_len_d    = err_len_q;
    err_id_d     = err_id_q;
    done_valid_d = '0;
    done_resp_d  = done_resp_q;

    bus.req_ready  = '0;
    bus.s_w_ready  = '0;
    bus.m_aw_id    = '0;
    bus.m_aw_addr  = '0;
    bus.m_aw_len   = '0;
    bus.m_aw_size  = '0;
    bus.m_aw_burst = '0;
    bus.m_aw_lock  = 1'b0;
    bus.m_aw_cache = '0;
    bus.m_aw_prot  = '0;
    bus.m_aw_qos   = '0;
    bus.m_aw_valid = 1'b0;
    bus.m_w_data   = '0;
    bus.m_w_strb   = '0;
    bus.m_w_last   = 1'b0;
    bus.m_w_valid  = 1'b0;
    bus.m_b_ready  = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          addr_d  = bus.req_addr[pick*AWIDTH +: AWIDTH];
          len_d   = bus.req_len[pick*8 +: 8];
          state_d = ADDR;
        end
      end
      ADDR: begin
        bus.m_aw_valid         = 1'b1;
        bus.m_aw_id            = IDWIDTH'(grant_q);
        bus.m_aw_addr          = addr_q;
        bus.m_aw_len           = len_q;
        bus.m_aw_size          = C_AW_SIZE;
        bus.m_aw_burst         = 2'b01;
        bus.req_ready[grant_q] = bus.m_aw_ready;
        if (bus.m_aw_ready) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        bus.m_w_valid          = bus.s_w_valid[grant_q];
        bus.m_w_data           = bus.s_w_data[grant_q*DWIDTH +: DWIDTH];
        bus.m_w_strb           = bus.s_w_strb[grant_q*SW +: SW];
        bus.m_w_last           = beat_last;
        bus.s_w_ready[grant_q] = bus.m_w_ready;
        // Framing comes from the counter; the requester's last flag is only audited.
        if (bus.m_w_valid && bus.m_w_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (bus.s_w_last[grant_q] != beat_last) err_len_d = 1'b1;
          if (beat_last) state_d = RESP;
        end
      end
      RESP: begin
        bus.m_b_ready = 1'b1;
        if (bus.m_b_valid) begin
          done_valid_d[grant_q] = 1'b1;
          done_resp_d           = bus.m_b_resp;
          if (bus.m_b_id != IDWIDTH'(grant_q)) err_id_d = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_PORTS - 1);
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      err_len_q    <= 1'b0;
      err_id_q     <= 1'b0;
      done_valid_q <= '0;
      done_resp_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      err_len_q    <= err_len_d;
      err_id_q     <= err_id_d;
      done_valid_q <= done_valid_d;
      done_resp_q  <= done_resp_d;
    end
  end

  assign bus.done_valid = done_valid_q;
  assign bus.done_resp  = done_resp_q;
  assign bus.err_len    = err_len_q;
  assign bus.err_id     = err_id_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi4_wr_arbiter : vector table of bursts plus fairness and reset sequences
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_axi4_wr_arbiter;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  axi4_wr_arbiter_if #(.NUM_PORTS(NP), .DWIDTH(DW), .AWIDTH(AW), .IDWIDTH(IW)) bus ();

  axi4_wr_arbiter #(.NUM_PORTS(NP), .DWIDTH(DW), .AWIDTH(AW), .IDWIDTH(IW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } wexp_t;

  typedef struct {
    int          port;
    logic [31:0] addr;
    int          len;
    int          mode;      // 0: full rate, 1: m_w_ready toggling and a 3-cycle source gap
    int          bad_last;  // beat index carrying s_w_last, or -1 for correct framing
    int          aw_stall;
    int          b_stall;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        exp_err_len;
    logic        exp_err_id;
  } vec_t;

  wexp_t wq[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int port, input logic [31:0] addr, input int b);
    return {8'(port), addr[23:0], 32'(b)};
  endfunction

  function automatic logic [SW-1:0] beat_strb(input int b);
    return 8'hFF ^ 8'(b * 3);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every forwarded W beat must match the next expected one.
  always @(negedge clk) begin
    wexp_t e;
    if (reset_n && bus.m_w_valid && bus.m_w_ready) begin
      if (wq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL w_unexpected: got beat %0h, required no beat", bus.m_w_data);
      end else begin
        e = wq.pop_front();
        chk("w_data", bus.m_w_data, e.data);
        chk("w_strb", 64'(bus.m_w_strb), 64'(e.strb));
        chk("w_last", 64'(bus.m_w_last), 64'(e.last));
      end
    end
  end

  task automatic clear_inputs();
    bus.req_valid  = '0;
    bus.req_addr   = '0;
    bus.req_len    = '0;
    bus.s_w_data   = '0;
    bus.s_w_strb   = '0;
    bus.s_w_last   = '0;
    bus.s_w_valid  = '0;
    bus.m_aw_ready = 1'b0;
    bus.m_w_ready  = 1'b0;
    bus.m_b_id     = '0;
    bus.m_b_resp   = '0;
    bus.m_b_valid  = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_aw_valid"}, 64'(bus.m_aw_valid), 64'd0);
    chk({tag, "_aw_fields"}, {bus.m_aw_id, bus.m_aw_addr, bus.m_aw_len, bus.m_aw_size, bus.m_aw_burst,
                              bus.m_aw_lock, bus.m_aw_cache, bus.m_aw_prot, bus.m_aw_qos}, 64'd0);
    chk({tag, "_w_valid"}, 64'(bus.m_w_valid), 64'd0);
    chk({tag, "_w_data"}, bus.m_w_data, 64'd0);
    chk({tag, "_w_last"}, 64'(bus.m_w_last), 64'd0);
    chk({tag, "_b_ready"}, 64'(bus.m_b_ready), 64'd0);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, "_s_w_ready"}, 64'(bus.s_w_ready), 64'd0);
    chk({tag, "_done_valid"}, 64'(bus.done_valid), 64'd0);
    chk({tag, "_done_resp"}, 64'(bus.done_resp), 64'd0);
    chk({tag, "_err_len"}, 64'(bus.err_len), 64'd0);
    chk({tag, "_err_id"}, 64'(bus.err_id), 64'd0);
  endtask

  // One complete burst for a single requester; called from an idle arbiter at posedge+1.
  task automatic run_burst(input vec_t v);
    int   bi;
    int   drop;
    int   cyc;
    int   t;
    logic sv;
    bus.req_valid[v.port]            = 1'b1;
    bus.req_addr[v.port*AW +: AW]    = v.addr;
    bus.req_len[v.port*8 +: 8]       = 8'(v.len);
    bus.s_w_valid[v.port]            = 1'b1;
    bus.s_w_data[v.port*DW +: DW]    = beat_data(v.port, v.addr, 0);
    bus.s_w_strb[v.port*SW +: SW]    = beat_strb(0);
    #1;
    chk("aw_valid_idle", 64'(bus.m_aw_valid), 64'd0);
    step();
    chk("done_one_cycle", 64'(bus.done_valid), 64'd0);
    for (t = 0; t <= v.aw_stall; t++) begin
      bus.m_aw_ready = (t == v.aw_stall);
      #1;
      chk("aw_valid", 64'(bus.m_aw_valid), 64'd1);
      chk("w_before_aw", 64'(bus.m_w_valid), 64'd0);
      chk("s_w_ready_in_addr", 64'(bus.s_w_ready), 64'd0);
      chk("req_ready", 64'(bus.req_ready), bus.m_aw_ready ? (64'd1 << v.port) : 64'd0);
      if (bus.m_aw_ready) begin
        chk("aw_id", 64'(bus.m_aw_id), 64'(v.port));
        chk("aw_addr", 64'(bus.m_aw_addr), 64'(v.addr));
        chk("aw_len", 64'(bus.m_aw_len), 64'(v.len));
        chk("aw_size_burst", {59'd0, bus.m_aw_size, bus.m_aw_burst}, 64'b011_01);
        chk("aw_misc", {bus.m_aw_lock, bus.m_aw_cache, bus.m_aw_prot, bus.m_aw_qos}, 64'd0);
      end
      step();
    end
    bus.m_aw_ready        = 1'b0;
    bus.req_valid[v.port] = 1'b0;

    for (int b = 0; b <= v.len; b++)
      wq.push_back('{data: beat_data(v.port, v.addr, b), strb: beat_strb(b), last: (b == v.len)});

    bi = 0; drop = 0; cyc = 0;
    while (bi <= v.len && cyc < 200) begin
      sv = 1'b1;
      if (v.mode == 1 && bi == 3 && drop < 3) begin
        sv = 1'b0;
        drop++;
      end
      bus.s_w_valid[v.port]         = sv;
      bus.s_w_data[v.port*DW +: DW] = beat_data(v.port, v.addr, bi);
      bus.s_w_strb[v.port*SW +: SW] = beat_strb(bi);
      bus.s_w_last[v.port]          = (v.bad_last >= 0) ? (bi == v.bad_last) : (bi == v.len);
      bus.m_w_ready                 = (v.mode == 1) ? (cyc % 2 == 1) : 1'b1;
      #1;
      chk("m_w_valid", 64'(bus.m_w_valid), 64'(sv));
      chk("s_w_ready", 64'(bus.s_w_ready), bus.m_w_ready ? (64'd1 << v.port) : 64'd0);
      if (sv && bus.m_w_ready) bi++;
      cyc++;
      step();
    end
    chk("w_beats_sent", 64'(bi), 64'(v.len + 1));
    bus.s_w_valid[v.port] = 1'b0;
    bus.s_w_last[v.port]  = 1'b0;
    bus.m_w_ready         = 1'b0;
    chk("wq_drained", 64'(wq.size()), 64'd0);
    wq.delete();

    for (t = 0; t <= v.b_stall; t++) begin
      bus.m_b_valid = (t == v.b_stall);
      bus.m_b_id    = v.bid;
      bus.m_b_resp  = v.bresp;
      #1;
      chk("b_ready", 64'(bus.m_b_ready), 64'd1);
      chk("done_quiet", 64'(bus.done_valid), 64'd0);
      step();
    end
    bus.m_b_valid = 1'b0;
    #1;
    chk("done_valid", 64'(bus.done_valid), 64'd1 << v.port);
    chk("done_resp", 64'(bus.done_resp), 64'(v.bresp));
    chk("err_len", 64'(bus.err_len), 64'(v.exp_err_len));
    chk("err_id", 64'(bus.err_id), 64'(v.exp_err_id));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    vec_t v;
    int   order[4];
    int   g;
    tbl[0] = '{port: 2, addr: 32'h1000, len: 3, mode: 0, bad_last: -1, aw_stall: 0, b_stall: 0,
               bresp: 2'b00, bid: 4'd2, exp_err_len: 1'b0, exp_err_id: 1'b0};
    tbl[1] = '{port: 1, addr: 32'h2040, len: 7, mode: 1, bad_last: -1, aw_stall: 1, b_stall: 2,
               bresp: 2'b00, bid: 4'd1, exp_err_len: 1'b0, exp_err_id: 1'b0};
    tbl[2] = '{port: 3, addr: 32'h3000, len: 0, mode: 0, bad_last: -1, aw_stall: 2, b_stall: 0,
               bresp: 2'b01, bid: 4'd3, exp_err_len: 1'b0, exp_err_id: 1'b0};
    tbl[3] = '{port: 0, addr: 32'h4000, len: 3, mode: 0, bad_last: 1, aw_stall: 0, b_stall: 1,
               bresp: 2'b00, bid: 4'd0, exp_err_len: 1'b1, exp_err_id: 1'b0};
    tbl[4] = '{port: 1, addr: 32'h5000, len: 2, mode: 0, bad_last: -1, aw_stall: 0, b_stall: 0,
               bresp: 2'b10, bid: 4'd0, exp_err_len: 1'b1, exp_err_id: 1'b1};
    tbl[5] = '{port: 2, addr: 32'h6000, len: 1, mode: 1, bad_last: -1, aw_stall: 0, b_stall: 1,
               bresp: 2'b11, bid: 4'd2, exp_err_len: 1'b1, exp_err_id: 1'b1};

    clear_inputs();
    reset_n = 1'b0;
    #1;
    check_zero_outputs("reset");
    step();
    step();
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_burst(tbl[i]);
    step();

    // Asynchronous reset in the middle of beat 3 of a len-7 burst.
    bus.req_valid[2]         = 1'b1;
    bus.req_addr[2*AW +: AW] = 32'h7000;
    bus.req_len[2*8 +: 8]    = 8'd7;
    step();
    bus.m_aw_ready = 1'b1;
    step();
    bus.m_aw_ready   = 1'b0;
    bus.req_valid[2] = 1'b0;
    for (int b = 0; b <= 7; b++)
      wq.push_back('{data: beat_data(2, 32'h7000, b), strb: beat_strb(b), last: (b == 7)});
    bus.m_w_ready    = 1'b1;
    bus.s_w_valid[2] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      bus.s_w_data[2*DW +: DW] = beat_data(2, 32'h7000, b);
      bus.s_w_strb[2*SW +: SW] = beat_strb(b);
      if (b < 2) step();
    end
    #1;
    chk("mid_burst_w_valid", 64'(bus.m_w_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    wq.delete();
    step();
    clear_inputs();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_stray_done", 64'(bus.done_valid), 64'd0);
    end
    v = '{port: 0, addr: 32'h8000, len: 3, mode: 0, bad_last: -1, aw_stall: 0, b_stall: 0,
          bresp: 2'b00, bid: 4'd0, exp_err_len: 1'b0, exp_err_id: 1'b0};
    run_burst(v);
    step();

    // Fairness: ports 0, 1 and 3 hold their requests; grants must go 0,1,3,0.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    order = '{0, 1, 3, 0};
    for (int p = 0; p < NP; p++) begin
      bus.req_addr[p*AW +: AW] = 32'h100 * p;
      bus.req_len[p*8 +: 8]    = 8'd0;
      bus.s_w_data[p*DW +: DW] = beat_data(p, 32'h100 * p, 0);
      bus.s_w_strb[p*SW +: SW] = beat_strb(p);
    end
    bus.req_valid  = 4'b1011;
    bus.s_w_valid  = 4'b1011;
    bus.s_w_last   = 4'b1011;
    bus.m_aw_ready = 1'b1;
    bus.m_w_ready  = 1'b1;
    bus.m_b_valid  = 1'b1;
    bus.m_b_resp   = 2'b00;
    step();
    for (int r = 0; r < 4; r++) begin
      g = order[r];
      bus.m_b_id = 4'(g);
      #1;
      chk("rr_aw_valid", 64'(bus.m_aw_valid), 64'd1);
      chk("rr_grant", 64'(bus.m_aw_id), 64'(g));
      chk("rr_req_ready", 64'(bus.req_ready), 64'd1 << g);
      chk("rr_s_w_ready_addr", 64'(bus.s_w_ready), 64'd0);
      wq.push_back('{data: beat_data(g, 32'h100 * g, 0), strb: beat_strb(g), last: 1'b1});
      step();
      chk("rr_s_w_ready", 64'(bus.s_w_ready), 64'd1 << g);
      chk("rr_req_ready_data", 64'(bus.req_ready), 64'd0);
      step();
      chk("rr_b_ready", 64'(bus.m_b_ready), 64'd1);
      step();
      if (r == 3) begin
        bus.req_valid = '0;
        bus.s_w_valid = '0;
      end
      chk("rr_done", 64'(bus.done_valid), 64'd1 << g);
      step();
    end
    chk("rr_wq_drained", 64'(wq.size()), 64'd0);
    chk("rr_err_id", 64'(bus.err_id), 64'd0);
    chk("rr_idle", 64'(bus.m_aw_valid), 64'd0);
    clear_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
